// File: rtl/regwrite_scheduler_if.sv
// Register-file write scheduler bus: two writeback requesters,
// the file's write port and the two bypassed read ports.
interface regwrite_scheduler_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 2
);
   logic              a_valid;
   logic [ADDR_W-1:0] a_wr;
   logic [DATA_W-1:0] a_wd;
   logic              a_ready;
   logic              b_valid;
   logic [ADDR_W-1:0] b_wr;
   logic [DATA_W-1:0] b_wd;
   logic              b_ready;
   logic [ADDR_W-1:0] rf_wr;
   logic [DATA_W-1:0] rf_wd;
   logic              rf_regwrite;
   logic [ADDR_W-1:0] rr1;
   logic [ADDR_W-1:0] rr2;
   logic [DATA_W-1:0] rf_rd1;
   logic [DATA_W-1:0] rf_rd2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              idle;

   modport master (
      output a_valid, a_wr, a_wd,
      output b_valid, b_wr, b_wd,
      output rr1, rr2, rf_rd1, rf_rd2,
      input  a_ready, b_ready,
      input  rf_wr, rf_wd, rf_regwrite,
      input  rd1, rd2, idle
   );

   modport slave (
      input  a_valid, a_wr, a_wd,
      input  b_valid, b_wr, b_wd,
      input  rr1, rr2, rf_rd1, rf_rd2,
      output a_ready, b_ready,
      output rf_wr, rf_wd, rf_regwrite,
      output rd1, rd2, idle
   );
endinterface

// File: rtl/regwrite_scheduler.sv
// Shares the register file write port between ALU (A) and load (B)
// writeback via 2-entry queues, round-robin arbitration and a commit stage.
module regwrite_scheduler #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 2
) (
   input logic                 clock,
   input logic                 reset_n,
   regwrite_scheduler_if.slave bus
);
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   logic              w_in_vld [2];
   logic [ADDR_W-1:0] w_in_wr  [2];
   logic [DATA_W-1:0] w_in_wd  [2];
   logic              w_ne     [2];
   logic              w_push   [2];
   logic              w_pop    [2];
   logic              w_grant;
   logic              w_sel;

   logic [1:0]        r_cnt  [2];
   logic [ADDR_W-1:0] r_q_wr [2][2];
   logic [DATA_W-1:0] r_q_wd [2][2];
   logic              r_last;
   logic              r_c_valid;
   logic [ADDR_W-1:0] r_c_wr;
   logic [DATA_W-1:0] r_c_wd;

   assign w_in_vld[0] = bus.a_valid;
   assign w_in_wr[0]  = bus.a_wr;
   assign w_in_wd[0]  = bus.a_wd;
   assign w_in_vld[1] = bus.b_valid;
   assign w_in_wr[1]  = bus.b_wr;
   assign w_in_wd[1]  = bus.b_wd;

   assign w_ne[0]   = (r_cnt[0] != 2'd0);
   assign w_ne[1]   = (r_cnt[1] != 2'd0);
   assign w_push[0] = w_in_vld[0] & (r_cnt[0] != 2'd2);
   assign w_push[1] = w_in_vld[1] & (r_cnt[1] != 2'd2);

   // B wins when it is alone, or on a tie when A was granted last
   assign w_sel   = (w_ne[1] & (!w_ne[0] | (r_last == SEL_A))) ? SEL_B : SEL_A;
   assign w_grant = w_ne[0] | w_ne[1];
   assign w_pop[0] = w_grant & (w_sel == SEL_A);
   assign w_pop[1] = w_grant & (w_sel == SEL_B);

   // slot 0 is always the queue head
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int q = 0; q < 2; q++) begin
            r_cnt[q] <= 2'd0;
            for (int s = 0; s < 2; s++) begin
               r_q_wr[q][s] <= '0;
               r_q_wd[q][s] <= '0;
            end
         end
      end else begin
         for (int q = 0; q < 2; q++) begin
            unique case ({w_push[q], w_pop[q]})
               2'b10: begin
                  r_cnt[q] <= r_cnt[q] + 2'd1;
                  if (r_cnt[q] == 2'd0) begin
                     r_q_wr[q][0] <= w_in_wr[q];
                     r_q_wd[q][0] <= w_in_wd[q];
                  end else begin
                     r_q_wr[q][1] <= w_in_wr[q];
                     r_q_wd[q][1] <= w_in_wd[q];
                  end
               end
               2'b01: begin
                  r_cnt[q]     <= r_cnt[q] - 2'd1;
                  r_q_wr[q][0] <= r_q_wr[q][1];
                  r_q_wd[q][0] <= r_q_wd[q][1];
               end
               2'b11: begin
                  r_q_wr[q][0] <= w_in_wr[q];
                  r_q_wd[q][0] <= w_in_wd[q];
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_last    <= SEL_B;
         r_c_valid <= 1'b0;
         r_c_wr    <= '0;
         r_c_wd    <= '0;
      end else begin
         r_c_valid <= w_grant;
         if (w_grant) begin
            r_last <= w_sel;
            r_c_wr <= r_q_wr[w_sel][0];
            r_c_wd <= r_q_wd[w_sel][0];
         end
      end
   end

   assign bus.a_ready     = (r_cnt[0] != 2'd2);
   assign bus.b_ready     = (r_cnt[1] != 2'd2);
   assign bus.rf_wr       = r_c_wr;
   assign bus.rf_wd       = r_c_wd;
   assign bus.rf_regwrite = r_c_valid & (r_c_wr != '0);
   assign bus.idle        = (r_cnt[0] == 2'd0) & (r_cnt[1] == 2'd0) & !r_c_valid;

   assign bus.rd1 = (bus.rr1 == '0) ? '0 :
                    (r_c_valid && (r_c_wr == bus.rr1)) ? r_c_wd : bus.rf_rd1;
   assign bus.rd2 = (bus.rr2 == '0) ? '0 :
                    (r_c_valid && (r_c_wr == bus.rr2)) ? r_c_wd : bus.rf_rd2;
endmodule

// File: tb/tb_regwrite_scheduler.sv
// Scoreboard bench for regwrite_scheduler: queue-level reference model
// feeds per-cycle expectations to an independent negedge monitor.
module tb_regwrite_scheduler;
   localparam int DW = 16;
   localparam int AW = 2;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   regwrite_scheduler_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   regwrite_scheduler #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   typedef struct packed {
      logic [AW-1:0] wr;
      logic [DW-1:0] wd;
   } wr_t;

   typedef struct {
      logic          cv;
      logic [AW-1:0] wr;
      logic [DW-1:0] wd;
      logic          ar;
      logic          br;
      logic          idle;
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
   } exp_t;

   wr_t  srca[$], srcb[$];
   wr_t  mqa[$], mqb[$];
   exp_t expq[$];
   logic mlast;
   logic mcv;
   wr_t  mc;
   int   force_rr = -1;
   int   checks   = 0;
   int   passed   = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
   endtask

   function automatic wr_t rand_item();
      wr_t t;
      t.wr = AW'($urandom);
      t.wd = DW'($urandom);
      return t;
   endfunction

   function automatic logic [DW-1:0] bypass(input logic [AW-1:0] rr,
                                            input logic [DW-1:0] raw);
      if (rr == '0) return '0;
      if (mcv && mc.wr == rr) return mc.wd;
      return raw;
   endfunction

   task automatic drive_inputs();
      bus.a_valid = (srca.size() != 0);
      bus.a_wr    = bus.a_valid ? srca[0].wr : AW'($urandom);
      bus.a_wd    = bus.a_valid ? srca[0].wd : DW'($urandom);
      bus.b_valid = (srcb.size() != 0);
      bus.b_wr    = bus.b_valid ? srcb[0].wr : AW'($urandom);
      bus.b_wd    = bus.b_valid ? srcb[0].wd : DW'($urandom);
      bus.rr1     = (force_rr >= 0) ? AW'(force_rr) : AW'($urandom);
      bus.rr2     = AW'($urandom);
      bus.rf_rd1  = DW'($urandom);
      bus.rf_rd2  = DW'($urandom);
   endtask

   task automatic model_clear();
      srca.delete(); srcb.delete();
      mqa.delete();  mqb.delete();
      expq.delete();
      mlast = 1'b1;
      mcv   = 1'b0;
      mc    = '0;
      drive_inputs();
   endtask

   // one clock: the model consumes the inputs present at the edge
   task automatic step();
      exp_t e;
      logic acca, accb;
      @(posedge clock); #1;
      acca = bus.a_valid && (mqa.size() < 2);
      accb = bus.b_valid && (mqb.size() < 2);
      if (mqa.size() != 0 && (mqb.size() == 0 || mlast)) begin
         mc = mqa.pop_front(); mcv = 1'b1; mlast = 1'b0;
      end else if (mqb.size() != 0) begin
         mc = mqb.pop_front(); mcv = 1'b1; mlast = 1'b1;
      end else begin
         mcv = 1'b0;
      end
      if (acca) mqa.push_back(srca.pop_front());
      if (accb) mqb.push_back(srcb.pop_front());
      drive_inputs();
      e.cv   = mcv;
      e.wr   = mc.wr;
      e.wd   = mc.wd;
      e.ar   = (mqa.size() < 2);
      e.br   = (mqb.size() < 2);
      e.idle = (mqa.size() == 0) && (mqb.size() == 0) && !mcv;
      e.rd1  = bypass(bus.rr1, bus.rf_rd1);
      e.rd2  = bypass(bus.rr2, bus.rf_rd2);
      expq.push_back(e);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((srca.size() || srcb.size() || mqa.size() || mqb.size() || mcv)
             && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", {31'd0, n >= budget}, 32'd0);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_regwrite"}, {31'd0, bus.rf_regwrite}, 32'd0);
      chk({tag, "_rf_wr"},    {30'd0, bus.rf_wr}, 32'd0);
      chk({tag, "_rf_wd"},    {16'd0, bus.rf_wd}, 32'd0);
      chk({tag, "_idle"},     {31'd0, bus.idle}, 32'd1);
      chk({tag, "_a_ready"},  {31'd0, bus.a_ready}, 32'd1);
      chk({tag, "_b_ready"},  {31'd0, bus.b_ready}, 32'd1);
      chk({tag, "_rd1"}, {16'd0, bus.rd1},
          {16'd0, (bus.rr1 == '0) ? 16'd0 : bus.rf_rd1});
   endtask

   task automatic reset_mid();
      #3;
      reset_n = 1'b0;
      model_clear();
      #1;
      reset_checks("rst_mid");
      repeat (2) begin
         @(posedge clock); #1;
         chk("rst_hold_regwrite", {31'd0, bus.rf_regwrite}, 32'd0);
         chk("rst_hold_idle", {31'd0, bus.idle}, 32'd1);
      end
      reset_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset_n && expq.size() != 0) begin
            e = expq.pop_front();
            chk("regwrite", {31'd0, bus.rf_regwrite},
                {31'd0, e.cv && (e.wr != '0)});
            chk("rf_wr", {30'd0, bus.rf_wr}, {30'd0, e.wr});
            chk("rf_wd", {16'd0, bus.rf_wd}, {16'd0, e.wd});
            chk("a_ready", {31'd0, bus.a_ready}, {31'd0, e.ar});
            chk("b_ready", {31'd0, bus.b_ready}, {31'd0, e.br});
            chk("idle", {31'd0, bus.idle}, {31'd0, e.idle});
            chk("rd1", {16'd0, bus.rd1}, {16'd0, e.rd1});
            chk("rd2", {16'd0, bus.rd2}, {16'd0, e.rd2});
         end
      end
   end

   initial begin : stim
      model_clear();
      repeat (2) @(posedge clock);
      #1;
      reset_checks("rst_init");
      reset_n = 1'b1;

      // one write committing, one queued, then reset
      srca.push_back('{wr: 2'd1, wd: 16'h1234});
      srca.push_back('{wr: 2'd1, wd: 16'h5678});
      step();
      step();
      reset_mid();

      // single A write, read port 1 watching r2
      force_rr = 2;
      srca.push_back('{wr: 2'd2, wd: 16'hBEEF});
      drain(10);
      force_rr = -1;
      step();

      // contention: A0 B0 A1 B1
      srca.push_back('{wr: 2'd1, wd: 16'h0001});
      srca.push_back('{wr: 2'd1, wd: 16'h0002});
      srcb.push_back('{wr: 2'd3, wd: 16'h0003});
      srcb.push_back('{wr: 2'd3, wd: 16'h0004});
      drain(20);

      // write to r0 is consumed without a file write
      force_rr = 0;
      srcb.push_back('{wr: 2'd0, wd: 16'hFFFF});
      drain(10);
      force_rr = -1;
      step();

      // backpressure: A streams 4 values against a busy B
      for (int i = 0; i < 4; i++) begin
         srca.push_back('{wr: 2'd2, wd: 16'hA000 + 16'(i)});
         srcb.push_back('{wr: 2'd3, wd: 16'hB000 + 16'(i)});
      end
      drain(40);

      // same-edge push/pop at count 1
      for (int i = 0; i < 6; i++)
         srca.push_back('{wr: 2'(1 + i % 3), wd: 16'hC000 + 16'(i)});
      drain(20);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) != 0 && srca.size() < 3) srca.push_back(rand_item());
         if ($urandom_range(0, 2) != 0 && srcb.size() < 3) srcb.push_back(rand_item());
         step();
      end
      drain(50);

      // random reset in the middle of traffic
      for (int i = 0; i < 5; i++) begin
         srca.push_back(rand_item());
         srcb.push_back(rand_item());
      end
      step();
      step();
      step();
      reset_mid();
      for (int i = 0; i < 100; i++) begin
         if ($urandom_range(0, 1) != 0 && srca.size() < 3) srca.push_back(rand_item());
         if ($urandom_range(0, 1) != 0 && srcb.size() < 3) srcb.push_back(rand_item());
         step();
      end
      drain(50);
      step();
      step();
      @(negedge clock);
      #1;
      chk("scoreboard_empty", expq.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
